// File: rtl/data_memory_unit.sv
// Load/store data memory stage: RISC-V byte/half/word accesses after a configurable
// wait, with a valid/ready request handshake so the core can stall while pending.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        resp_valid,
    output logic        error,
    output logic [1:0]  dbg_state
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t        r_state, w_next_state;
    logic [3:0]    r_count;
    logic          r_store, r_err;
    logic [2:0]    r_funct3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_read_data;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept, w_req_err, w_f3_ok, w_misaligned, w_access;
    logic          w_acc_store;
    logic [2:0]    w_acc_f3;
    logic [AW+1:0] w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic [AW-1:0] w_index;
    logic [1:0]    w_lane;
    logic [31:0]   w_word, w_shifted, w_load, w_wshift;
    logic [3:0]    w_be;
    logic          w_unused_addr;

    // Upper address bits wrap onto the array and are deliberately dropped.
    assign w_unused_addr = ^addr[31:AW+2];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready and
    // (mem_read || mem_write); req_ready is high only in IDLE, and every accepted
    // request is answered by exactly one resp_valid pulse, with error qualifying it.
    assign w_accept = (r_state == S_IDLE) && req_valid && (mem_read || mem_write);

    always_comb begin
        w_f3_ok = 1'b0;
        if (mem_write) w_f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
        else           w_f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_req_err    = (mem_read && mem_write) || !w_f3_ok || w_misaligned;
    end

    // With zero latency the access happens on the accept edge, so it uses the live inputs.
    assign w_access    = (w_accept && !w_req_err && ZERO_LAT) ||
                         ((r_state == S_WAIT) && (r_count == 4'd0));
    assign w_acc_store = (r_state == S_IDLE) ? mem_write : r_store;
    assign w_acc_f3    = (r_state == S_IDLE) ? funct3 : r_funct3;
    assign w_acc_addr  = (r_state == S_IDLE) ? addr[AW+1:0] : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? write_data : r_wdata;
    assign w_index     = w_acc_addr[AW+1:2];
    assign w_lane      = w_acc_addr[1:0];
    assign w_word      = r_mem[w_index];
    assign w_shifted   = w_word >> {w_lane, 3'b000};

    always_comb begin
        case (w_acc_f3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_word;
        endcase
        case (w_acc_f3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << w_lane;
                w_wshift = {4{w_acc_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = 4'b0011 << w_lane;
                w_wshift = {2{w_acc_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wshift = w_acc_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= 4'd0;
            r_store  <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_count  <= LAT_M1;
                r_store  <= mem_write;
                r_err    <= w_req_err;
                r_funct3 <= funct3;
                r_addr   <= addr[AW+1:0];
                r_wdata  <= write_data;
            end else if ((r_state == S_WAIT) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data <= 32'd0;
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
        end else if (w_access) begin
            if (w_acc_store) begin
                for (int b = 0; b < 4; b++)
                    if (w_be[b]) r_mem[w_index][b*8 +: 8] <= w_wshift[b*8 +: 8];
            end else begin
                r_read_data <= w_load;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = (w_req_err || ZERO_LAT) ? S_RESP : S_WAIT;
            S_WAIT: if (r_count == 4'd0) w_next_state = S_RESP;
            S_RESP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        error      = (r_state == S_RESP) && r_err;
        read_data  = r_read_data;
        dbg_state  = r_state;
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: a zero-latency and a two-cycle instance driven by
// directed and random requests, checked against a byte-array reference model.
module tb_data_memory_unit;
    localparam int DEPTH     = 256;
    localparam int MEM_BYTES = DEPTH * 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: LATENCY=0 instance, index 1: LATENCY=2 instance
    logic [1:0]  rst, req_valid, req_ready, mem_read, mem_write, resp_valid, error;
    logic [2:0]  funct3    [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic [1:0]  dbg_state [2];

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .funct3(funct3[0]),
        .addr(addr[0]), .write_data(wdata[0]), .read_data(rdata[0]),
        .resp_valid(resp_valid[0]), .error(error[0]), .dbg_state(dbg_state[0])
    );

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .funct3(funct3[1]),
        .addr(addr[1]), .write_data(wdata[1]), .read_data(rdata[1]),
        .resp_valid(resp_valid[1]), .error(error[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard / reference model ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  mbytes [2][MEM_BYTES];
    logic [31:0] mlast  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic model_reset(input int k);
        for (int i = 0; i < MEM_BYTES; i++) mbytes[k][i] = 8'h00;
        mlast[k] = 32'd0;
    endtask

    // Applies one request to the model; returns whether it should be rejected.
    task automatic model_access(input int k, input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, output bit err);
        int n, base;
        logic [31:0] v;
        err = rd && wr;
        if (wr) err = err || !(f3 inside {3'd0, 3'd1, 3'd2});
        else    err = err || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) err = 1'b1;
        if (err) return;
        n    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = int'(a % MEM_BYTES);
        if (wr) begin
            for (int i = 0; i < n; i++) mbytes[k][base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[k][base + i];
            if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            mlast[k] = v;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_req(input int k, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        bit exp_err, seen;
        int cyc;
        model_access(k, rd, wr, f3, a, wd, exp_err);
        exp_q.push_back(mlast[k]);
        check_eq("ready_before", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; mem_read[k] = rd; mem_write[k] = wr;
        funct3[k] = f3; addr[k] = a; wdata[k] = wd;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0; mem_read[k] = 1'($urandom); mem_write[k] = 1'($urandom);
        funct3[k] = 3'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = resp_valid[k];
        end
        check_eq("resp_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(cyc), exp_err ? 32'd1 : 32'(lat_of(k) + 1));
        check_eq("error", 32'(error[k]), 32'(exp_err));
        check_eq("read_data", rdata[k], exp_q.pop_front());
        @(negedge clk);
        check_eq("resp_pulse", 32'(resp_valid[k]), 32'd0);
        check_eq("error_idle", 32'(error[k]), 32'd0);
        check_eq("ready_after", 32'(req_ready[k]), 32'd1);
    endtask

    task automatic check_idle_outputs(input int k, input logic [31:0] exp_rd);
        check_eq("rst_ready", 32'(req_ready[k]), 32'd1);
        check_eq("rst_resp", 32'(resp_valid[k]), 32'd0);
        check_eq("rst_error", 32'(error[k]), 32'd0);
        check_eq("rst_rdata", rdata[k], exp_rd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit rd, wr;
        logic [2:0] f3;
        logic [31:0] a;
        int r;

        rst = 2'b11; req_valid = 2'b00; mem_read = 2'b00; mem_write = 2'b00;
        for (int k = 0; k < 2; k++) begin
            funct3[k] = 3'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
            model_reset(k);
        end
        repeat (3) @(negedge clk);
        check_idle_outputs(0, 32'd0);
        check_idle_outputs(1, 32'd0);
        rst = 2'b00;
        @(negedge clk);
        check_idle_outputs(0, 32'd0);
        check_idle_outputs(1, 32'd0);

        // Reset in the middle of a store's wait must abort it and clear the array.
        run_req(1, 0, 1, 3'b010, 32'h10, 32'h1111_1111);
        run_req(1, 1, 0, 3'b010, 32'h10, 32'h0);
        req_valid[1] = 1'b1; mem_write[1] = 1'b1; mem_read[1] = 1'b0;
        funct3[1] = 3'b010; addr[1] = 32'h10; wdata[1] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0; mem_write[1] = 1'b0;
        @(negedge clk);
        check_eq("wait_not_ready", 32'(req_ready[1]), 32'd0);
        rst[1] = 1'b1;
        #1;
        model_reset(1);
        check_idle_outputs(1, 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        run_req(1, 1, 0, 3'b010, 32'h10, 32'h0);
        check_eq("lw_after_reset", rdata[1], 32'h0000_0000);

        // Width / sign coverage on the two-cycle instance.
        run_req(1, 0, 1, 3'b010, 32'h20, 32'h8081_82F3);
        run_req(1, 1, 0, 3'b010, 32'h20, 32'h0);
        check_eq("lw_const", rdata[1], 32'h8081_82F3);
        run_req(1, 1, 0, 3'b000, 32'h20, 32'h0);
        check_eq("lb_const", rdata[1], 32'hFFFF_FFF3);
        run_req(1, 1, 0, 3'b100, 32'h23, 32'h0);
        check_eq("lbu_const", rdata[1], 32'h0000_0080);
        run_req(1, 1, 0, 3'b001, 32'h22, 32'h0);
        check_eq("lh_const", rdata[1], 32'hFFFF_8081);
        run_req(1, 1, 0, 3'b101, 32'h20, 32'h0);
        check_eq("lhu_const", rdata[1], 32'h0000_82F3);
        run_req(1, 0, 1, 3'b000, 32'h21, 32'h0000_00AA);
        run_req(1, 1, 0, 3'b010, 32'h20, 32'h0);
        check_eq("sb_merge", rdata[1], 32'h8081_AAF3);

        // Misaligned and illegal requests.
        run_req(1, 1, 0, 3'b010, 32'h22, 32'h0);
        run_req(1, 0, 1, 3'b001, 32'h23, 32'h5555_5555);
        run_req(1, 1, 1, 3'b010, 32'h20, 32'h7777_7777);
        run_req(1, 1, 0, 3'b011, 32'h20, 32'h0);
        run_req(1, 0, 1, 3'b100, 32'h20, 32'h9999_9999);
        check_eq("err_keeps_rdata", rdata[1], 32'h8081_AAF3);
        run_req(1, 1, 0, 3'b010, 32'h20, 32'h0);
        check_eq("err_keeps_array", rdata[1], 32'h8081_AAF3);

        // req_valid without read or write is ignored.
        req_valid[1] = 1'b1; mem_read[1] = 1'b0; mem_write[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("noop_resp", 32'(resp_valid[1]), 32'd0);
            check_eq("noop_ready", 32'(req_ready[1]), 32'd1);
        end
        req_valid[1] = 1'b0;

        // Address wrap on both instances; zero-latency timing.
        for (int k = 0; k < 2; k++) begin
            run_req(k, 0, 1, 3'b010, 32'h400, 32'h1234_5678);
            run_req(k, 1, 0, 3'b010, 32'h000, 32'h0);
            check_eq("wrap_const", rdata[k], 32'h1234_5678);
        end

        // Randomized traffic.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                rd = 1'($urandom_range(0, 1));
                wr = 1'($urandom_range(0, 1));
                if (!rd && !wr) rd = 1'b1;
                if (rd && wr && $urandom_range(0, 7) != 0) wr = 1'b0;
                r = $urandom_range(0, 9);
                if (r < 8) f3 = wr ? 3'($urandom_range(0, 2)) : 3'(r % 3 + (r > 4 ? 4 : 0));
                else       f3 = 3'($urandom_range(0, 7));
                if (f3 == 3'd6) f3 = 3'd2;
                a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 7)) << 10);
                if ($urandom_range(0, 3) != 0 && f3[1:0] == 2'd1) a[0] = 1'b0;
                if ($urandom_range(0, 3) != 0 && f3[1:0] == 2'd2) a[1:0] = 2'b00;
                run_req(k, rd, wr, f3, a, $urandom);
            end
        end

        // ---------------- final report ----------------
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
